// File: rtl/acc_seq_pkg.sv
// Shared types and default parameters for the accumulator sequencer.
// The array width and buffer address width match the accumulator stage
// that this sequencer drives.
package acc_seq_pkg;

   localparam int ACC_ARR_SIZE = 4;
   localparam int ACC_ADDR_W   = 4;
   localparam int ACC_CNT_W    = 8;

   // Sequencer states, one per phase of an output tile
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      ACCUM = 3'd2,
      DRAIN = 3'd3,
      STORE = 3'd4,
      DONE  = 3'd5
   } seq_state_t;

   // The reduction adder chain is ARR_SIZE deep; one extra cycle covers
   // the register at the end of the chain before the result can be stored.
   function automatic int default_drain_cycles(input int arr_size);
      return arr_size + 1;
   endfunction

endpackage

// File: rtl/accumulator_sequencer.sv
// Control FSM for the accumulator stage below the systolic array.
// Per output tile: clear the accumulators, count partial-sum passes,
// wait for the reduction chain to settle, then store the tile to the
// output buffer with a ready handshake at an auto-incrementing address.
// All outputs are registered and decoded from the next state, so they
// line up with the state register and drop to 0 immediately on reset.
module accumulator_sequencer
   import acc_seq_pkg::*;
#(
   parameter int ARR_SIZE     = ACC_ARR_SIZE,
   parameter int ADDR_W       = ACC_ADDR_W,
   parameter int CNT_W        = ACC_CNT_W,
   parameter int DRAIN_CYCLES = default_drain_cycles(ARR_SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_tiles,
   input  logic [CNT_W-1:0]  num_passes,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              pass_done,
   input  logic              obuf_ready,
   output logic              acc_reset,
   output logic              store_output,
   output logic [ADDR_W-1:0] op_buffer_address,
   output logic              busy,
   output logic              done,
   output logic              pass_err
);

   seq_state_t        state;
   seq_state_t        state_next;

   logic [CNT_W-1:0]  num_tiles_q;
   logic [CNT_W-1:0]  num_passes_q;
   logic [ADDR_W-1:0] base_q;

   logic [CNT_W-1:0]  tile_idx;
   logic [CNT_W-1:0]  pass_cnt;
   logic [CNT_W-1:0]  drain_cnt;

   logic              accept_start;
   logic              count_pass;
   logic              last_pass;
   logic              store_fire;
   logic              last_tile;
   logic              err_set;
   logic [CNT_W-1:0]  pass_cnt_inc;
   logic [ADDR_W-1:0] store_addr;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode plus the per-cycle strobes that steer the counters
   always_comb begin
      state_next   = state;
      accept_start = 1'b0;
      count_pass   = 1'b0;
      last_pass    = 1'b0;
      store_fire   = 1'b0;
      pass_cnt_inc = pass_cnt + CNT_W'(1);
      last_tile    = (tile_idx == (num_tiles_q - CNT_W'(1)));
      store_addr   = base_q + ADDR_W'(tile_idx);
      err_set      = pass_done && (state != ACCUM);

      unique case (state)
         IDLE: begin
            if (start) begin
               if ((num_tiles != '0) && (num_passes != '0)) begin
                  accept_start = 1'b1;
                  state_next   = CLEAR;
               end else begin
                  state_next   = DONE;
               end
            end
         end
         CLEAR: begin
            state_next = ACCUM;
         end
         ACCUM: begin
            if (pass_done) begin
               count_pass = 1'b1;
               if (pass_cnt_inc == num_passes_q) begin
                  last_pass  = 1'b1;
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drain_cnt <= CNT_W'(1)) begin
               state_next = STORE;
            end
         end
         STORE: begin
            if (obuf_ready) begin
               store_fire = 1'b1;
               state_next = last_tile ? DONE : CLEAR;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Job configuration latched on an accepted start and held for the job
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         num_tiles_q  <= '0;
         num_passes_q <= '0;
         base_q       <= '0;
      end else if (accept_start) begin
         num_tiles_q  <= num_tiles;
         num_passes_q <= num_passes;
         base_q       <= base_addr;
      end
   end

   // Tile index: restarts with each job, advances on a non-final store
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tile_idx <= '0;
      end else if (accept_start) begin
         tile_idx <= '0;
      end else if (store_fire && !last_tile) begin
         tile_idx <= tile_idx + CNT_W'(1);
      end
   end

   // Pass counter: zeroed while clearing, counts pass_done only in ACCUM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass_cnt <= '0;
      end else if (state == CLEAR) begin
         pass_cnt <= '0;
      end else if (count_pass) begin
         pass_cnt <= pass_cnt_inc;
      end
   end

   // Drain counter: loaded on the last pass, counts down through DRAIN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drain_cnt <= '0;
      end else if (last_pass) begin
         drain_cnt <= CNT_W'(DRAIN_CYCLES);
      end else if ((state == DRAIN) && (drain_cnt != '0)) begin
         drain_cnt <= drain_cnt - CNT_W'(1);
      end
   end

   // Registered Moore outputs decoded from the state being entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_reset         <= 1'b0;
         store_output      <= 1'b0;
         op_buffer_address <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
      end else begin
         acc_reset         <= (state_next == CLEAR);
         store_output      <= (state_next == STORE);
         op_buffer_address <= (state_next == STORE) ? store_addr : '0;
         busy              <= (state_next != IDLE);
         done              <= (state_next == DONE);
      end
   end

   // Sticky error flag for pass_done arriving outside ACCUM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass_err <= 1'b0;
      end else if (accept_start) begin
         pass_err <= 1'b0;
      end else if (err_set) begin
         pass_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Scoreboard bench for accumulator_sequencer. The job driver works out
// from the tile/pass/drain timing rules when each acc_reset, store and
// done pulse must appear and queues them; the monitor pops and compares
// whenever the DUT presents one of those outputs.
module tb_accumulator_sequencer;

   localparam int ADDR_W    = 4;
   localparam int CNT_W     = 8;
   localparam int DRAIN     = 4 + 1;
   localparam int EV_CLEAR  = 0;
   localparam int EV_STORE  = 1;
   localparam int EV_DONE   = 2;
   localparam int DONT_CARE = -1;

   typedef struct {
      int kind;
      int addr;
      int cyc;
      int err;
      int len;
   } ev_t;

   logic              clk        = 1'b0;
   logic              rst        = 1'b0;
   logic              start      = 1'b0;
   logic [CNT_W-1:0]  num_tiles  = '0;
   logic [CNT_W-1:0]  num_passes = '0;
   logic [ADDR_W-1:0] base_addr  = '0;
   logic              pass_done  = 1'b0;
   logic              obuf_ready = 1'b0;
   logic              acc_reset;
   logic              store_output;
   logic [ADDR_W-1:0] op_buffer_address;
   logic              busy;
   logic              done;
   logic              pass_err;

   ev_t exp_q[$];
   int  cyc_cnt   = 0;
   int  n_checks  = 0;
   int  n_fail    = 0;
   int  model_err = 0;
   bit  store_prev;
   int  store_len;

   accumulator_sequencer #(
      .ARR_SIZE (4),
      .ADDR_W   (ADDR_W),
      .CNT_W    (CNT_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .num_tiles         (num_tiles),
      .num_passes        (num_passes),
      .base_addr         (base_addr),
      .pass_done         (pass_done),
      .obuf_ready        (obuf_ready),
      .acc_reset         (acc_reset),
      .store_output      (store_output),
      .op_buffer_address (op_buffer_address),
      .busy              (busy),
      .done              (done),
      .pass_err          (pass_err)
   );

   // Free-running clock and edge counter used to timestamp events
   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check_output(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_cnt);
      end
   endtask

   task automatic report_unexpected(input string name);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: output pulse with no expected event (cycle %0d)", name, cyc_cnt);
   endtask

   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   // Runs one job; inputs change 1 time unit after a rising edge, so a value
   // driven at count c is sampled by the DUT at edge c+1.
   task automatic apply_stimulus(input int tiles, input int passes, input int base,
                                 input bit err_in_clear, input bit start_in_accum,
                                 input int stall_sel);
      int e;
      int t;
      int h;
      int stall;
      int gap;
      start      = 1'b1;
      num_tiles  = CNT_W'(tiles);
      num_passes = CNT_W'(passes);
      base_addr  = ADDR_W'(base);
      e = cyc_cnt + 1;
      if ((tiles == 0) || (passes == 0)) begin
         exp_q.push_back('{EV_DONE, 0, e, DONT_CARE, 0});
         wait_edge();
         start = 1'b0;
         wait_edge();
         check_output("zero_job_busy_after", int'(busy), 0);
         check_output("zero_job_done_after", int'(done), 0);
         return;
      end
      model_err = 0;
      exp_q.push_back('{EV_CLEAR, 0, e, 0, 0});
      wait_edge();
      start = 1'b0;
      for (int k = 0; k < tiles; k++) begin
         if (err_in_clear && (k == 0)) begin
            pass_done = 1'b1;
            model_err = 1;
         end
         wait_edge();
         pass_done = 1'b0;
         if (start_in_accum && (k == 0)) begin
            start      = 1'b1;
            num_tiles  = CNT_W'(1);
            num_passes = CNT_W'(1);
            base_addr  = ADDR_W'(base + 7);
            wait_edge();
            start = 1'b0;
         end
         for (int p = 0; p < passes; p++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) wait_edge();
            pass_done = 1'b1;
            wait_edge();
            pass_done = 1'b0;
         end
         t = cyc_cnt;
         stall = (stall_sel < 0) ? int'($urandom_range(0, 3)) : stall_sel;
         exp_q.push_back('{EV_STORE, (base + k) % (1 << ADDR_W), t + DRAIN, model_err, stall + 1});
         repeat (DRAIN) begin
            obuf_ready = 1'($urandom_range(0, 1));
            wait_edge();
         end
         obuf_ready = 1'b0;
         repeat (stall) wait_edge();
         obuf_ready = 1'b1;
         h = cyc_cnt + 1;
         if (k == tiles - 1) begin
            exp_q.push_back('{EV_DONE, 0, h, model_err, 0});
         end else begin
            exp_q.push_back('{EV_CLEAR, 0, h, model_err, 0});
         end
         wait_edge();
         obuf_ready = 1'b0;
      end
      wait_edge();
      check_output("job_busy_after_done", int'(busy), 0);
      check_output("job_done_one_cycle", int'(done), 0);
   endtask

   // Abandons a job in ACCUM with an asynchronous reset
   task automatic reset_mid_job();
      start      = 1'b1;
      num_tiles  = CNT_W'(3);
      num_passes = CNT_W'(4);
      base_addr  = ADDR_W'(2);
      exp_q.push_back('{EV_CLEAR, 0, cyc_cnt + 1, 0, 0});
      wait_edge();
      start = 1'b0;
      wait_edge();
      pass_done = 1'b1;
      wait_edge();
      pass_done = 1'b0;
      wait_edge();
      check_output("mid_busy_before_rst", int'(busy), 1);
      #2;
      rst = 1'b0;
      #1;
      check_output("mid_rst_acc_reset", int'(acc_reset), 0);
      check_output("mid_rst_store", int'(store_output), 0);
      check_output("mid_rst_addr", int'(op_buffer_address), 0);
      check_output("mid_rst_busy", int'(busy), 0);
      check_output("mid_rst_done", int'(done), 0);
      check_output("mid_rst_pass_err", int'(pass_err), 0);
      check_output("mid_rst_queue", exp_q.size(), 0);
      exp_q.delete();
      wait_edge();
      wait_edge();
      rst = 1'b1;
      model_err = 0;
      wait_edge();
   endtask

   // Monitor: pops the expected event whenever the DUT presents an output pulse
   initial begin
      ev_t ev;
      store_prev = 1'b0;
      store_len  = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            store_prev = 1'b0;
            store_len  = 0;
         end else begin
            if (acc_reset) begin
               if (exp_q.size() == 0) begin
                  report_unexpected("acc_reset");
               end else begin
                  ev = exp_q.pop_front();
                  check_output("clear_kind", EV_CLEAR, ev.kind);
                  check_output("clear_cycle", cyc_cnt, ev.cyc);
                  if (ev.err != DONT_CARE) check_output("clear_pass_err", int'(pass_err), ev.err);
               end
            end
            if (store_output) begin
               if (exp_q.size() == 0) begin
                  report_unexpected("store_output");
               end else begin
                  ev = exp_q[0];
                  check_output("store_kind", EV_STORE, ev.kind);
                  if (ev.kind == EV_STORE) begin
                     if (!store_prev) check_output("store_rise_cycle", cyc_cnt, ev.cyc);
                     check_output("store_addr", int'(op_buffer_address), ev.addr);
                     store_len++;
                     if (obuf_ready) begin
                        check_output("store_len", store_len, ev.len);
                        if (ev.err != DONT_CARE) check_output("store_pass_err", int'(pass_err), ev.err);
                        void'(exp_q.pop_front());
                        store_len = 0;
                     end
                  end
               end
            end
            if (done) begin
               if (exp_q.size() == 0) begin
                  report_unexpected("done");
               end else begin
                  ev = exp_q.pop_front();
                  check_output("done_kind", EV_DONE, ev.kind);
                  check_output("done_cycle", cyc_cnt, ev.cyc);
                  check_output("done_busy", int'(busy), 1);
                  if (ev.err != DONT_CARE) check_output("done_pass_err", int'(pass_err), ev.err);
               end
            end
            store_prev = store_output;
         end
      end
   end

   // Hard time limit so the run always ends
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: time limit reached, got running, expected finished");
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: reset, directed jobs, then randomized jobs
   initial begin
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("rst_acc_reset", int'(acc_reset), 0);
      check_output("rst_store", int'(store_output), 0);
      check_output("rst_addr", int'(op_buffer_address), 0);
      check_output("rst_busy", int'(busy), 0);
      check_output("rst_done", int'(done), 0);
      check_output("rst_pass_err", int'(pass_err), 0);
      rst = 1'b1;
      wait_edge();
      check_output("post_rst_busy", int'(busy), 0);

      apply_stimulus(2, 3, 5, 1'b0, 1'b0, 0);
      wait_edge();
      apply_stimulus(1, 2, 9, 1'b0, 1'b0, 4);
      wait_edge();
      apply_stimulus(2, 1, 15, 1'b0, 1'b0, 0);
      wait_edge();
      apply_stimulus(3, 0, 4, 1'b0, 1'b0, 0);
      apply_stimulus(0, 2, 4, 1'b0, 1'b0, 0);
      wait_edge();
      apply_stimulus(2, 2, 3, 1'b1, 1'b0, -1);
      check_output("err_sticky_idle", int'(pass_err), 1);
      wait_edge();
      apply_stimulus(2, 3, 1, 1'b0, 1'b1, -1);
      check_output("err_cleared_by_start", int'(pass_err), 0);
      wait_edge();
      reset_mid_job();
      for (int j = 0; j < 12; j++) begin
         apply_stimulus($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 15),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
         repeat ($urandom_range(0, 2)) wait_edge();
      end
      repeat (4) wait_edge();
      check_output("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
